// File: rtl/xvc_pkg.sv
// Shared types and defaults for the XVC JTAG shift engine.
package xvc_pkg;

    localparam int WORD_W   = 32;
    localparam int MAX_BITS = 32768;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LD_TMS,
        LD_TDI,
        LOW,
        HIGH,
        EMIT
    } shift_state_t;

    // Keeps the low n bits of a word; n may be the full 32.
    function automatic word_t low_mask(input logic [5:0] n);
        return (n >= 6'd32) ? '1 : ((word_t'(1) << n) - word_t'(1));
    endfunction

endpackage

// File: rtl/xvc_tck_gen.sv
// TCK half-period timer: strobes phase_end on the last cycle of each half
// period and toggles tck there; held idle (tck=0) whenever disabled.
module xvc_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic phase_end,
    output logic tck
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign phase_end = enable && (cnt == CW'(TCK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (phase_end) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/xvc_jtag_shifter.sv
// Replays XVC "shift:" packets bit-serially on TCK/TMS/TDI and returns the
// captured TDO as 32-bit words, bit 0 being the first bit shifted.
module xvc_jtag_shifter
    import xvc_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int MAX_BITS = xvc_pkg::MAX_BITS,
    parameter int WORD_W   = xvc_pkg::WORD_W
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  start_port,
    output logic  done_port,
    input  word_t in_data,
    input  logic  in_valid,
    output logic  in_ready,
    output word_t out_data,
    output logic  out_valid,
    input  logic  out_ready,
    output logic  out_last,
    output logic  tck,
    output logic  tms,
    output logic  tdi,
    input  logic  tdo,
    output logic  error
);

    shift_state_t state;
    word_t        bits_left;
    word_t        tms_sr;
    word_t        tdi_sr;
    word_t        tdo_sr;
    logic [4:0]   bit_idx;
    logic [5:0]   chunk_bits;

    logic              tck_en;
    logic              phase_end;
    logic              in_hs;
    logic              out_hs;
    logic              last_bit;
    logic [WORD_W-1:0] tdo_next;

    assign tck_en   = (state == LOW) || (state == HIGH);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign last_bit = ({1'b0, bit_idx} == (chunk_bits - 6'd1));
    assign tdo_next = tdo_sr | (word_t'(tdo) << bit_idx);

    xvc_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clock    (clock),
        .reset    (reset),
        .enable   (tck_en),
        .phase_end(phase_end),
        .tck      (tck)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tms        <= 1'b1;
            tdi        <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            done_port  <= 1'b0;
            error      <= 1'b0;
            bits_left  <= '0;
            tms_sr     <= '0;
            tdi_sr     <= '0;
            tdo_sr     <= '0;
            bit_idx    <= '0;
            chunk_bits <= '0;
        end else begin
            done_port <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_port) begin
                        state    <= HDR;
                        in_ready <= 1'b1;
                    end
                end
                HDR: begin
                    if (in_hs) begin
                        bits_left <= in_data;
                        if (in_data == '0) begin
                            done_port <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= IDLE;
                        end else if (in_data > word_t'(MAX_BITS)) begin
                            // Remaining words of the packet are left for upstream to flush.
                            error     <= 1'b1;
                            done_port <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= LD_TMS;
                        end
                    end
                end
                LD_TMS: begin
                    if (in_hs) begin
                        tms_sr <= in_data;
                        state  <= LD_TDI;
                    end
                end
                LD_TDI: begin
                    if (in_hs) begin
                        tdi_sr     <= in_data;
                        chunk_bits <= (bits_left >= word_t'(32)) ? 6'd32 : bits_left[5:0];
                        bit_idx    <= '0;
                        tms        <= tms_sr[0];
                        tdi        <= in_data[0];
                        in_ready   <= 1'b0;
                        state      <= LOW;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        tdo_sr    <= tdo_next;
                        bits_left <= bits_left - word_t'(1);
                        if (last_bit) begin
                            out_valid <= 1'b1;
                            out_data  <= tdo_next & low_mask(chunk_bits);
                            out_last  <= (bits_left == word_t'(1));
                            state     <= EMIT;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            tms     <= tms_sr[bit_idx + 5'd1];
                            tdi     <= tdi_sr[bit_idx + 5'd1];
                            state   <= LOW;
                        end
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        tdo_sr    <= '0;
                        if (bits_left == '0) begin
                            done_port <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= LD_TMS;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// Scoreboard bench for xvc_jtag_shifter: random packets against a word/bit
// level reference, with TDO modelled as TDI xor TMS.
module tb_xvc_jtag_shifter;

    localparam int TCK_DIV  = 2;
    localparam int MAX_BITS = 32768;

    logic        clock;
    logic        reset;
    logic        start_port;
    logic        done_port;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        error;

    assign tdo = tdi ^ tms;

    xvc_jtag_shifter #(
        .TCK_DIV (TCK_DIV),
        .MAX_BITS(MAX_BITS),
        .WORD_W  (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start_port(start_port),
        .done_port (done_port),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } out_exp_t;

    int          total = 0;
    int          bad   = 0;
    out_exp_t    exp_out[$];
    logic [1:0]  exp_bits[$];
    logic [31:0] tms_q[$];
    logic [31:0] tdi_q[$];
    int          done_count = 0;
    int          tck_rises  = 0;
    logic        tck_prev   = 1'b0;
    bit          exp_error  = 1'b0;
    bit          stall_mode = 1'b0;
    bit          stall_fired = 1'b0;
    int          stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output-side backpressure: random, or a long stall at the first EMIT.
    always @(posedge clock) begin
        #1;
        if (!stall_mode) begin
            stall_fired = 1'b0;
            stall_left  = 0;
        end
        if (stall_left > 0) begin
            stall_left--;
            out_ready = 1'b0;
        end else if (stall_mode && !stall_fired) begin
            out_ready = 1'b0;
            if (out_valid) begin
                stall_fired = 1'b1;
                stall_left  = 20;
            end
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: JTAG bit stream, TDO words, done pulses, stall behaviour.
    always @(negedge clock) begin
        if (reset) begin
            tck_prev = 1'b0;
        end else begin
            if (done_port) done_count++;
            if (tck && !tck_prev) begin
                tck_rises++;
                if (exp_bits.size() == 0) begin
                    check("extra tck edge", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = exp_bits.pop_front();
                    check("tms/tdi at tck rise", {30'd0, tms, tdi}, {30'd0, e});
                end
            end
            tck_prev = tck;
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    check("unexpected out word", 1, 0);
                end else begin
                    out_exp_t x;
                    x = exp_out.pop_front();
                    check("out_data", out_data, x.data);
                    check("out_last", {31'd0, out_last}, {31'd0, x.last});
                end
            end
            if (stall_left > 0) begin
                check("tck during stall", {31'd0, tck}, 0);
                check("in_ready during stall", {31'd0, in_ready}, 0);
            end
        end
    end

    task automatic build_expect(input int nb);
        int nwords;
        nwords = (nb + 31) / 32;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] tw;
            logic [31:0] dw;
            tw = tms_q[i / 32];
            dw = tdi_q[i / 32];
            exp_bits.push_back({tw[i % 32], dw[i % 32]});
        end
        for (int c = 0; c < nwords; c++) begin
            int          len;
            logic [31:0] mask;
            out_exp_t    x;
            len  = (nb - 32 * c > 32) ? 32 : nb - 32 * c;
            mask = (len == 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
            x.data = (tms_q[c] ^ tdi_q[c]) & mask;
            x.last = (c == nwords - 1);
            exp_out.push_back(x);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        if (!ok) check("in_ready timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int nb, input bit stall);
        int  base_done;
        int  base_rises;
        int  nwords;
        int  exp_edges;
        bit  seen;
        base_done  = done_count;
        base_rises = tck_rises;
        nwords     = (nb + 31) / 32;
        exp_edges  = (nb >= 1 && nb <= MAX_BITS) ? nb : 0;
        stall_mode = stall;
        if (exp_edges > 0) build_expect(nb);
        start_port = 1'b1;
        send_word(nb);
        start_port = 1'b0;
        if (exp_edges == 0) begin
            @(negedge clock);
            check("done after header", {31'd0, done_port}, 1);
            if (nb > MAX_BITS) exp_error = 1'b1;
        end else begin
            for (int c = 0; c < nwords; c++) begin
                send_word(tms_q[c]);
                send_word(tdi_q[c]);
            end
        end
        seen = 1'b0;
        for (int n = 0; n < 2000 + nb * 16; n++) begin
            if (done_count > base_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!seen) check("done timeout", 0, 1);
        repeat (3) @(negedge clock);
        checkOutput(nb, base_done, base_rises, exp_edges);
        stall_mode = 1'b0;
    endtask

    task automatic checkOutput(input int nb, input int base_done, input int base_rises,
                               input int exp_edges);
        check($sformatf("done pulses nb=%0d", nb), done_count - base_done, 1);
        check($sformatf("tck edges nb=%0d", nb), tck_rises - base_rises, exp_edges);
        check("out words drained", exp_out.size(), 0);
        check("jtag bits drained", exp_bits.size(), 0);
        check("error flag", {31'd0, error}, {31'd0, exp_error});
        check("in_ready idle", {31'd0, in_ready}, 0);
        check("tck idle", {31'd0, tck}, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " tck"}, {31'd0, tck}, 0);
        check({tag, " tms"}, {31'd0, tms}, 1);
        check({tag, " tdi"}, {31'd0, tdi}, 0);
        check({tag, " in_ready"}, {31'd0, in_ready}, 0);
        check({tag, " out_valid"}, {31'd0, out_valid}, 0);
        check({tag, " out_last"}, {31'd0, out_last}, 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " done_port"}, {31'd0, done_port}, 0);
        check({tag, " error"}, {31'd0, error}, 0);
    endtask

    initial begin
        reset      = 1'b1;
        start_port = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        tms_q = '{32'h0000_001F};
        tdi_q = '{32'h0000_000A};
        applyStimulus(5, 1'b0);

        tms_q = '{32'h0, 32'h0};
        tdi_q = '{32'hDEAD_BEEF, 32'h0000_00A5};
        applyStimulus(40, 1'b1);

        applyStimulus(0, 1'b0);

        for (int p = 0; p < 16; p++) begin
            int nb;
            nb = (p == 0) ? 32 : (p == 1) ? 33 : (p == 2) ? 1 : $urandom_range(1, 100);
            tms_q.delete();
            tdi_q.delete();
            for (int c = 0; c < (nb + 31) / 32; c++) begin
                tms_q.push_back($urandom);
                tdi_q.push_back($urandom);
            end
            applyStimulus(nb, 1'b0);
        end

        applyStimulus(MAX_BITS + 1, 1'b0);
        tms_q = '{$urandom};
        tdi_q = '{$urandom};
        applyStimulus(20, 1'b0);

        // Abort a 32-bit shift after three bits, then confirm recovery.
        begin
            int  base_rises;
            bit  seen;
            tms_q = '{$urandom};
            tdi_q = '{$urandom};
            build_expect(32);
            base_rises = tck_rises;
            start_port = 1'b1;
            send_word(32);
            start_port = 1'b0;
            send_word(tms_q[0]);
            send_word(tdi_q[0]);
            seen = 1'b0;
            for (int n = 0; n < 500; n++) begin
                if (tck_rises - base_rises >= 3) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            if (!seen) check("mid-shift tck timeout", 0, 1);
            #2;
            reset = 1'b1;
            #1;
            check_reset_values("async reset");
            exp_error = 1'b0;
            exp_bits.delete();
            exp_out.delete();
            repeat (2) @(posedge clock);
            #1;
            reset = 1'b0;
        end

        tms_q = '{$urandom, $urandom};
        tdi_q = '{$urandom, $urandom};
        applyStimulus(45, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
